// File: rtl/io_function_decode_read_block_if.sv
// CPU-side read bus for the IO read decoder: address/strobe in, busy/data/valid back.
// io_rd_err exists only when IO_RD_TIMEOUT_EN is defined.
`timescale 1ns/1ps

interface io_function_decode_read_block_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 16
);
    logic [ADDRESS_WIDTH-1:0] cpu_addr;
    logic                     io_rd;
    logic                     io_busy;
    logic [DATA_WIDTH-1:0]    io_din;
    logic                     io_rd_valid;
`ifdef IO_RD_TIMEOUT_EN
    logic                     io_rd_err;
`endif

    modport master (
        output cpu_addr,
        output io_rd,
        input  io_busy,
        input  io_din,
`ifdef IO_RD_TIMEOUT_EN
        input  io_rd_err,
`endif
        input  io_rd_valid
    );

    modport slave (
        input  cpu_addr,
        input  io_rd,
        output io_busy,
        output io_din,
`ifdef IO_RD_TIMEOUT_EN
        output io_rd_err,
`endif
        output io_rd_valid
    );
endinterface

// File: rtl/io_function_decode_read_block.sv
// CPU read decoder for the IO window: hands reads to px_clk over a 4-phase req/ack
// handshake and returns the sampled register. Optional abort timer: IO_RD_TIMEOUT_EN.
`timescale 1ns/1ps

module io_function_decode_read_block #(
    parameter int                       DATA_WIDTH    = 16,
    parameter int                       ADDRESS_WIDTH = 16,
    parameter int                       BLOCK_SIZE    = 5,
    parameter logic [ADDRESS_WIDTH-1:0] IO_BASE_ADDR  = ADDRESS_WIDTH'(16'h1000),
    parameter logic [ADDRESS_WIDTH-1:0] IO_BASE_MASK  = {ADDRESS_WIDTH{1'b1}} << BLOCK_SIZE,
    parameter int                       NUM_REGS      = 4
`ifdef IO_RD_TIMEOUT_EN
    ,
    parameter int                       TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           px_clk,
    io_function_decode_read_block_if.slave bus,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_REGS-1:0]            re
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK_LOW} state_t;

    // clk domain
    state_t                  r_state;
    logic                    r_req;
    logic [BLOCK_SIZE-1:0]   r_offset;
    logic [DATA_WIDTH-1:0]   r_io_din;
    logic                    r_io_rd_valid;
    logic                    r_ack_s1;
    logic                    r_ack_sync;
    logic                    w_hit;
    logic                    w_accept;

    // px_clk domain
    logic                    r_px_rst_s1;
    logic                    r_px_rst;
    logic                    r_req_s1;
    logic                    r_req_s;
    logic                    r_ack;
    logic [DATA_WIDTH-1:0]   r_hold;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic [NUM_REGS-1:0]     w_sel_re;

`ifdef IO_RD_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0]         r_to_cnt;
    logic                    r_io_rd_err;

    assign bus.io_rd_err = r_io_rd_err;
`endif

    assign w_hit    = ((bus.cpu_addr & IO_BASE_MASK) == IO_BASE_ADDR) & bus.io_rd;
    // A stale ack still draining from an aborted or reset transaction must not be taken as a response.
    assign w_accept = (r_state == IDLE) & w_hit & ~r_ack_sync;

    assign bus.io_busy     = (r_state != IDLE);
    assign bus.io_din      = r_io_din;
    assign bus.io_rd_valid = r_io_rd_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack_s1   <= 1'b0;
            r_ack_sync <= 1'b0;
        end else begin
            r_ack_s1   <= r_ack;
            r_ack_sync <= r_ack_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_req         <= 1'b0;
            r_offset      <= '0;
            r_io_din      <= '0;
            r_io_rd_valid <= 1'b0;
`ifdef IO_RD_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_io_rd_err   <= 1'b0;
`endif
        end else begin
            r_io_rd_valid <= 1'b0;
`ifdef IO_RD_TIMEOUT_EN
            r_io_rd_err   <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
`ifdef IO_RD_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                    if (w_accept) begin
                        r_offset <= bus.cpu_addr[BLOCK_SIZE-1:0];
                        r_req    <= 1'b1;
                        r_state  <= REQ;
                    end
                end
                REQ: begin
                    // r_hold is frozen while ack is high, so it is sampled without a synchronizer.
                    if (r_ack_sync) begin
                        r_io_din      <= r_hold;
                        r_io_rd_valid <= 1'b1;
                        r_req         <= 1'b0;
                        r_state       <= WAIT_ACK_LOW;
                    end
`ifdef IO_RD_TIMEOUT_EN
                    else if (r_to_cnt == TO_LAST) begin
                        r_io_din      <= '1;
                        r_io_rd_valid <= 1'b1;
                        r_io_rd_err   <= 1'b1;
                        r_req         <= 1'b0;
                        r_state       <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                WAIT_ACK_LOW: begin
                    if (!r_ack_sync) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge px_clk) begin
        r_px_rst_s1 <= rst;
        r_px_rst    <= r_px_rst_s1;
    end

    // r_offset is held steady while req is high, so it crosses without synchronization.
    always_comb begin
        w_sel_data = '0;
        w_sel_re   = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (32'(r_offset) == k) begin
                w_sel_data  = rd_data[k*DATA_WIDTH +: DATA_WIDTH];
                w_sel_re[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge px_clk) begin
        if (r_px_rst) begin
            r_req_s1 <= 1'b0;
            r_req_s  <= 1'b0;
            r_ack    <= 1'b0;
            r_hold   <= '0;
            re       <= '0;
        end else begin
            r_req_s1 <= r_req;
            r_req_s  <= r_req_s1;
            re       <= '0;
            if (r_req_s && !r_ack) begin
                r_hold <= w_sel_data;
                re     <= w_sel_re;
                r_ack  <= 1'b1;
            end else if (!r_req_s && r_ack) begin
                r_ack <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_io_function_decode_read_block.sv
// Scoreboard bench for io_function_decode_read_block: stimulus queues expected data and
// strobes, negedge monitors pop and compare. Define IO_RD_TIMEOUT_EN to add the abort test.
`timescale 1ns/1ps

module tb_io_function_decode_read_block;

    localparam int BOUND = 600;

    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        px_clk;
    logic        px_async;
    logic [1:0]  px_mode;   // 0: px_clk = clk, 1: async 3:7, 2: stopped
    logic [63:0] rd_data;
    logic [3:0]  re;

    int n_vec = 0;
    int n_err = 0;
    exp_t exp_q[$];
    int   re_q[$];

    io_function_decode_read_block_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16)) bus ();

    io_function_decode_read_block dut (
        .clk     (clk),
        .rst     (rst),
        .px_clk  (px_clk),
        .bus     (bus),
        .rd_data (rd_data),
        .re      (re)
    );

    initial begin
        clk = 1'b0;
        forever #3 clk = ~clk;
    end

    initial begin
        px_async = 1'b0;
        #1;
        forever #7 px_async = ~px_async;
    end

    assign px_clk = (px_mode == 2'd0) ? clk : (px_mode == 2'd1) ? px_async : 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.io_rd_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got io_din=%0h required no response", bus.io_din);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("io_din", 32'(bus.io_din), 32'(e.data));
`ifdef IO_RD_TIMEOUT_EN
                chk("io_rd_err", 32'(bus.io_rd_err), 32'(e.err));
`endif
            end
        end
`ifdef IO_RD_TIMEOUT_EN
        if (!rst && !bus.io_rd_valid && bus.io_rd_err) begin
            n_vec++;
            n_err++;
            $display("FAIL err_without_valid: got io_rd_err=1 required 0");
        end
`endif
    end

    always @(negedge px_clk) begin
        if (!rst && re != 4'd0) begin
            if (re_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_re: got re=%0h required 0", re);
            end else begin
                int idx;
                idx = re_q.pop_front();
                chk("re_onehot", 32'(re), 32'(1) << idx);
            end
        end
    end

    // Issue one io_rd and follow the transaction until io_busy drops.
    task automatic run_read(input logic [15:0] addr, input bit acc, input logic [15:0] exp_d,
                            input int exp_re, input bit exp_err, input int exp_lat,
                            input int exp_busy, input int inj_at, input logic [15:0] inj_addr);
        int c;
        int first_v;
        int nv;
        exp_t e;
        @(negedge clk);
        bus.cpu_addr = addr;
        bus.io_rd    = 1'b1;
        if (acc) begin
            e.data = exp_d;
            e.err  = exp_err;
            exp_q.push_back(e);
            if (exp_re >= 0) re_q.push_back(exp_re);
        end
        @(negedge clk);
        bus.io_rd = 1'b0;
        c = 0;
        first_v = -1;
        nv = 0;
        forever begin
            if (bus.io_rd_valid) begin
                nv++;
                if (first_v < 0) first_v = c;
            end
            if (!bus.io_busy || c >= BOUND) break;
            @(negedge clk);
            c++;
            if (c == inj_at) begin
                bus.cpu_addr = inj_addr;
                bus.io_rd    = 1'b1;
            end else if (c == inj_at + 1) begin
                bus.io_rd = 1'b0;
            end
        end
        chk("busy_within_bound", 32'(c < BOUND), 32'd1);
        chk("valid_count", 32'(nv), acc ? 32'd1 : 32'd0);
        if (exp_lat >= 0) chk("valid_latency", 32'(first_v), 32'(exp_lat));
        if (exp_busy >= 0) chk("busy_cycles", 32'(c), 32'(exp_busy));
    endtask

    task automatic expect_quiet(input int cycles);
        int stray;
        stray = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.io_busy || bus.io_rd_valid) stray++;
        end
        chk("quiet_after_miss", 32'(stray), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nv;
        px_mode      = 2'd0;
        rst          = 1'b1;
        bus.io_rd    = 1'b0;
        bus.cpu_addr = '0;
        rd_data      = {16'hDEAD, 16'hBEEF, 16'h1234, 16'hA5A5};
        repeat (6) @(negedge clk);
        chk("rst_io_din", 32'(bus.io_din), 32'd0);
        chk("rst_io_rd_valid", 32'(bus.io_rd_valid), 32'd0);
        chk("rst_io_busy", 32'(bus.io_busy), 32'd0);
        chk("rst_re", 32'(re), 32'd0);
`ifdef IO_RD_TIMEOUT_EN
        chk("rst_io_rd_err", 32'(bus.io_rd_err), 32'd0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Same-frequency reads with exact latency
        run_read(16'h1000, 1, 16'hA5A5, 0, 0, 6, 12, -1, 16'h0);
        run_read(16'h1003, 1, 16'hDEAD, 3, 0, 6, 12, -1, 16'h0);

        // Asynchronous px_clk at 3:7
        px_mode = 2'd1;
        run_read(16'h1001, 1, 16'h1234, 1, 0, -1, -1, -1, 16'h0);
        run_read(16'h1002, 1, 16'hBEEF, 2, 0, -1, -1, -1, 16'h0);
        @(negedge clk);
        px_mode = 2'd0;
        repeat (4) @(negedge clk);

        // Address misses
        run_read(16'h1100, 0, 16'h0, -1, 0, -1, 0, -1, 16'h0);
        expect_quiet(20);
        run_read(16'h0FFF, 0, 16'h0, -1, 0, -1, 0, -1, 16'h0);
        expect_quiet(20);
        run_read(16'h1020, 0, 16'h0, -1, 0, -1, 0, -1, 16'h0);
        expect_quiet(20);

        // Unmapped offset: zero data, no strobe, full handshake
        run_read(16'h101F, 1, 16'h0000, -1, 0, 6, 12, -1, 16'h0);

        // Back-to-back: read during busy is dropped, then serviced once idle
        run_read(16'h1002, 1, 16'hBEEF, 2, 0, 6, 12, 3, 16'h1001);
        run_read(16'h1001, 1, 16'h1234, 1, 0, 6, 12, -1, 16'h0);

`ifdef IO_RD_TIMEOUT_EN
        @(negedge clk);
        px_mode = 2'd2;
        run_read(16'h1000, 1, 16'hFFFF, -1, 1, 255, 255, -1, 16'h0);
        @(negedge clk);
        px_mode = 2'd0;
        repeat (4) @(negedge clk);
`endif

        // Reset while waiting in REQ with px_clk stopped
        @(negedge clk);
        px_mode = 2'd2;
        @(negedge clk);
        bus.cpu_addr = 16'h1003;
        bus.io_rd    = 1'b1;
        @(negedge clk);
        bus.io_rd = 1'b0;
        nv = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.io_rd_valid) nv++;
        end
        chk("stalled_busy", 32'(bus.io_busy), 32'd1);
        chk("stalled_no_valid", 32'(nv), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_io_busy", 32'(bus.io_busy), 32'd0);
        chk("midrst_io_din", 32'(bus.io_din), 32'd0);
        chk("midrst_io_rd_valid", 32'(bus.io_rd_valid), 32'd0);
        px_mode = 2'd0;
        repeat (4) @(negedge clk);
        chk("midrst_re", 32'(re), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_read(16'h1000, 1, 16'hA5A5, 0, 0, 6, 12, -1, 16'h0);

        repeat (10) @(negedge clk);
        chk("data_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("re_queue_drained", 32'(re_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
